// File: rtl/alu_311.sv
// 4-bit ALU with 16 opcodes and a registered 8-bit result (1-cycle latency).
// Optional registered {C,Z} flags output enabled by defining ALU311_FLAGS_EN.
module alu_311 (
  input  logic       Clk_311,
  input  logic       Rst_311,
  input  logic [3:0] In1_311,
  input  logic [3:0] In2_311,
  input  logic [3:0] Sel_311,
  output logic [7:0] Out_311
`ifdef ALU311_FLAGS_EN
  ,
  output logic [1:0] Flags_311
`endif
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NAND = 4'd7,
    OP_NOR  = 4'd8,  OP_XNOR = 4'd9,  OP_NOT  = 4'd10, OP_SHL  = 4'd11,
    OP_SHR  = 4'd12, OP_ROL  = 4'd13, OP_CMP  = 4'd14, OP_CAT  = 4'd15
  } opcode_e;

  opcode_e    op;
  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] sum;
  logic [7:0] rot_pair;
  logic [7:0] result;

  assign op       = opcode_e'(Sel_311);
  assign a_ext    = {4'h0, In1_311};
  assign b_ext    = {4'h0, In2_311};
  assign sum      = a_ext + b_ext;
  // Rotating a doubled copy leaves the 4-bit rotation in the upper nibble.
  assign rot_pair = {In1_311, In1_311} << In2_311[1:0];

  always_comb begin
    // NOTE: default assigned before the case so no path leaves result unassigned (no latch).
    result = 8'h00;
    case (op)
      OP_ADD:  result = sum;
      OP_SUB:  result = a_ext - b_ext;
      OP_MUL:  result = a_ext * b_ext;
      OP_DIV:  result = (In2_311 == 4'h0) ? 8'hFF
                                          : {In1_311 % In2_311, In1_311 / In2_311};
      OP_AND:  result = {4'h0, In1_311 & In2_311};
      OP_OR:   result = {4'h0, In1_311 | In2_311};
      OP_XOR:  result = {4'h0, In1_311 ^ In2_311};
      OP_NAND: result = {4'h0, ~(In1_311 & In2_311)};
      OP_NOR:  result = {4'h0, ~(In1_311 | In2_311)};
      OP_XNOR: result = {4'h0, ~(In1_311 ^ In2_311)};
      OP_NOT:  result = {4'h0, ~In1_311};
      OP_SHL:  result = a_ext << In2_311[2:0];
      OP_SHR:  result = a_ext >> In2_311[2:0];
      OP_ROL:  result = {4'h0, rot_pair[7:4]};
      OP_CMP:  result = {5'b0, In1_311 > In2_311, In1_311 == In2_311, In1_311 < In2_311};
      OP_CAT:  result = {In1_311, In2_311};
      default: result = 8'h00;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_311) begin
    if (Rst_311) Out_311 <= 8'h00;
    else         Out_311 <= result;
  end

`ifdef ALU311_FLAGS_EN
  logic carry;

  always_comb begin
    carry = 1'b0;
    case (op)
      OP_ADD:  carry = sum[4];
      OP_SUB:  carry = In1_311 < In2_311;
      OP_DIV:  carry = (In2_311 == 4'h0);
      default: carry = 1'b0;
    endcase
  end

  always_ff @(posedge Clk_311) begin
    if (Rst_311) Flags_311 <= 2'b00;
    else         Flags_311 <= {carry, result == 8'h00};
  end
`endif

endmodule

// File: tb/tb_alu_311.sv
// Self-checking bench for alu_311: directed opcode cases, mid-stream reset,
// then randomized traffic against an arithmetic reference model.
module tb_alu_311;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] sel;
  logic [7:0] out;
`ifdef ALU311_FLAGS_EN
  logic [1:0] flags;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_out   = 8'h00;
  logic [1:0] exp_flags = 2'b00;
  bit         primed    = 1'b0;

  alu_311 dut (
    .Clk_311 (clk),
    .Rst_311 (rst),
    .In1_311 (in1),
    .In2_311 (in2),
    .Sel_311 (sel),
    .Out_311 (out)
`ifdef ALU311_FLAGS_EN
    ,
    .Flags_311 (flags)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ref_out(input int s, input int a, input int b);
    case (s)
      0:  return a + b;
      1:  return (a - b + 256) % 256;
      2:  return a * b;
      3:  return (b == 0) ? 255 : (a % b) * 16 + a / b;
      4:  return a & b;
      5:  return a | b;
      6:  return a ^ b;
      7:  return 15 - (a & b);
      8:  return 15 - (a | b);
      9:  return 15 - (a ^ b);
      10: return 15 - a;
      11: return (a * (1 << (b % 8))) % 256;
      12: return a / (1 << (b % 8));
      13: return ((a * (1 << (b % 4))) % 16) + a / (1 << (4 - b % 4)) % 16;
      14: return (a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0);
      default: return a * 16 + b;
    endcase
  endfunction

  function automatic int ref_carry(input int s, input int a, input int b);
    if (s == 0) return (a + b > 15) ? 1 : 0;
    if (s == 1) return (a < b) ? 1 : 0;
    if (s == 3) return (b == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one operation mid-cycle, confirms the output has not moved yet,
  // then checks the registered result just after the next rising edge.
  task automatic step(input bit r, input int s, input int a, input int b, input string tag);
    int e;
    @(negedge clk);
    rst = r; sel = 4'(s); in1 = 4'(a); in2 = 4'(b);
    #1;
    if (primed) check({tag, "_hold"}, out, exp_out);
    e = r ? 0 : ref_out(s, a, b);
    exp_out   = 8'(e);
    exp_flags = r ? 2'b00 : {1'(ref_carry(s, a, b)), (e == 0) ? 1'b1 : 1'b0};
    @(posedge clk);
    #1;
    primed = 1'b1;
    check(tag, out, exp_out);
`ifdef ALU311_FLAGS_EN
    check({tag, "_flags"}, {6'b0, flags}, {6'b0, exp_flags});
`endif
  endtask

  initial begin
    rst = 1'b1; sel = '0; in1 = '0; in2 = '0;

    step(1, 15, 4'hF, 4'hF, "reset0");
    step(1, 2, 4'h9, 4'h7, "reset1");
    step(0, 0, 7, 9, "add_7_9");
    step(0, 0, 15, 15, "add_15_15");
    step(0, 1, 3, 5, "sub_3_5");
    step(0, 1, 9, 9, "sub_9_9");
    step(0, 2, 15, 15, "mul_15_15");
    step(0, 3, 13, 4, "div_13_4");
    step(0, 3, 5, 0, "div_5_0");
    step(0, 4, 12, 10, "and");
    step(0, 5, 12, 10, "or");
    step(0, 6, 12, 10, "xor");
    step(0, 7, 12, 10, "nand");
    step(0, 8, 12, 10, "nor");
    step(0, 9, 12, 10, "xnor");
    step(0, 10, 12, 10, "not");
    step(0, 11, 9, 3, "shl");
    step(0, 12, 9, 2, "shr");
    step(0, 13, 9, 1, "rol");
    step(0, 14, 5, 3, "cmp_gt");
    step(0, 14, 3, 3, "cmp_eq");
    step(0, 15, 10, 5, "cat");
    step(1, 15, 10, 5, "midreset");
    step(0, 2, 3, 3, "after_reset");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
